// File: rtl/chnl_slave_node.sv
// Channel receive buffer: first-word-fall-through FIFO between a channel agent
// and the downstream arbiter, with free-space and packet-ready reporting.
module chnl_slave_node #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    ch_data,
  input  logic          ch_valid,
  output logic          ch_ready,
  input  logic          slv_en,
  input  logic [2:0]    pkt_len,
  input  logic          slv_pop,
  output logic          slv_val,
  output logic [7:0]    slv_data,
  output logic          slv_req,
  output logic [AW:0]   margin
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [AW:0]   pkt_words;
  logic          push;
  logic          pop;

  // Ready depends only on registered count so the agent never sees a
  // combinational path from its own valid.
  assign ch_ready = rstn && slv_en && (count_reg != DEPTH_C);
  assign slv_val  = (count_reg != '0);
  assign push     = ch_valid && ch_ready;
  assign pop      = slv_pop && slv_val;
  assign slv_data = slv_val ? mem[rd_ptr_reg] : 8'h00;
  assign margin   = DEPTH_C - count_reg;
  assign slv_req  = slv_en && (count_reg >= pkt_words);

  always_comb begin
    pkt_words = (AW+1)'(32);
    case (pkt_len)
      3'd0:    pkt_words = (AW+1)'(4);
      3'd1:    pkt_words = (AW+1)'(8);
      3'd2:    pkt_words = (AW+1)'(16);
      default: pkt_words = (AW+1)'(32);
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= ch_data;
  end

endmodule

// File: tb/tb_chnl_slave_node.sv
// Self-checking bench for chnl_slave_node: constant vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_chnl_slave_node;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    ch_data;
  logic          ch_valid;
  logic          ch_ready;
  logic          slv_en;
  logic [2:0]    pkt_len;
  logic          slv_pop;
  logic          slv_val;
  logic [7:0]    slv_data;
  logic          slv_req;
  logic [AW:0]   margin;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  chnl_slave_node #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .slv_en(slv_en), .pkt_len(pkt_len), .slv_pop(slv_pop),
    .slv_val(slv_val), .slv_data(slv_data), .slv_req(slv_req), .margin(margin)
  );

  typedef struct {
    logic        en;
    logic        v;
    logic [7:0]  d;
    logic        p;
    logic [2:0]  pl;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic en, logic v, logic [7:0] d, logic p, logic [2:0] pl,
                              logic rdy, logic val, logic [7:0] dat, logic req, logic [5:0] mg);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.p = p; r.pl = pl;
    r.exp = {rdy, val, dat, req, mg};
    return r;
  endfunction

  // Output bundle: {ch_ready, slv_val, slv_data, slv_req, margin}
  function automatic logic [16:0] dut_out();
    return {ch_ready, slv_val, slv_data, slv_req, margin};
  endfunction

  function automatic logic [16:0] model_out();
    int n;
    int pw;
    logic r;
    logic [7:0] head;
    n    = q.size();
    pw   = (pkt_len == 3'd0) ? 4 : (pkt_len == 3'd1) ? 8 : (pkt_len == 3'd2) ? 16 : 32;
    r    = rstn && slv_en && (n < DEPTH);
    head = (n > 0) ? q[0] : 8'h00;
    return {r, (n > 0), head, (slv_en && (n >= pw)), 6'(DEPTH - n)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rs, input logic en, input logic v, input logic [7:0] d,
                       input logic p, input logic [2:0] pl);
    @(negedge clk);
    rstn = rs; slv_en = en; ch_valid = v; ch_data = d; slv_pop = p; pkt_len = pl;
    #1;
  endtask

  // Advance one edge and update the model from the inputs presented to it.
  task automatic commit();
    bit do_push;
    bit do_pop;
    logic [7:0] d;
    do_push = ch_valid && rstn && slv_en && (q.size() < DEPTH);
    do_pop  = slv_pop && (q.size() > 0);
    d = ch_data;
    @(posedge clk);
    if (!rstn) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  task automatic cyc(input logic rs, input logic en, input logic v, input logic [7:0] d,
                     input logic p, input logic [2:0] pl, input string name);
    apply(rs, en, v, d, p, pl);
    check(name, 32'(dut_out()), 32'(model_out()));
    commit();
  endtask

  initial begin
    rstn = 1'b0; slv_en = 1'b0; ch_valid = 1'b0; ch_data = 8'h00; slv_pop = 1'b0; pkt_len = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_state", 32'(dut_out()), 32'({1'b0, 1'b0, 8'h00, 1'b0, 6'd32}));

    // Table: expectations are the outputs seen before the edge that applies the row.
    tbl[0]  = mk(1, 1, 8'h01, 0, 1,  1, 0, 8'h00, 0, 6'd32);
    tbl[1]  = mk(1, 1, 8'h02, 0, 1,  1, 1, 8'h01, 0, 6'd31);
    tbl[2]  = mk(1, 1, 8'h03, 0, 1,  1, 1, 8'h01, 0, 6'd30);
    tbl[3]  = mk(1, 1, 8'h04, 0, 1,  1, 1, 8'h01, 0, 6'd29);
    tbl[4]  = mk(1, 1, 8'h05, 0, 1,  1, 1, 8'h01, 0, 6'd28);
    tbl[5]  = mk(1, 0, 8'h00, 1, 1,  1, 1, 8'h01, 0, 6'd27);
    tbl[6]  = mk(1, 0, 8'h00, 1, 1,  1, 1, 8'h02, 0, 6'd28);
    tbl[7]  = mk(1, 0, 8'h00, 1, 1,  1, 1, 8'h03, 0, 6'd29);
    tbl[8]  = mk(1, 0, 8'h00, 1, 1,  1, 1, 8'h04, 0, 6'd30);
    tbl[9]  = mk(1, 0, 8'h00, 1, 1,  1, 1, 8'h05, 0, 6'd31);
    tbl[10] = mk(1, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 6'd32);
    tbl[11] = mk(1, 1, 8'hAA, 1, 1,  1, 0, 8'h00, 0, 6'd32);
    tbl[12] = mk(0, 0, 8'h00, 0, 1,  0, 1, 8'hAA, 0, 6'd31);
    tbl[13] = mk(1, 0, 8'h00, 0, 0,  1, 1, 8'hAA, 0, 6'd31);
    tbl[14] = mk(1, 0, 8'h00, 1, 0,  1, 1, 8'hAA, 0, 6'd31);
    tbl[15] = mk(1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 6'd32);
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].pl);
      $display("vec %0d en=%0b v=%0b d=%h pop=%0b pl=%0d out=%h", i, tbl[i].en, tbl[i].v,
               tbl[i].d, tbl[i].p, tbl[i].pl, dut_out());
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
      commit();
    end

    // Fill to full, 33rd word held off until a pop reopens ready.
    for (int i = 0; i < 32; i++) cyc(1, 1, 1, 8'($urandom), 0, 3, "fill");
    apply(1, 1, 1, 8'hC3, 0, 3);
    check("full_ready", 32'(ch_ready), 32'(0));
    check("full_margin", 32'(margin), 32'(0));
    commit();
    apply(1, 1, 1, 8'hC3, 1, 3);
    check("full_pop_ready", 32'(ch_ready), 32'(0));
    check("full_pop", 32'(dut_out()), 32'(model_out()));
    commit();
    apply(1, 1, 1, 8'hC3, 0, 3);
    check("reopen_ready", 32'(ch_ready), 32'(1));
    commit();
    for (int i = 0; i < 32; i++) cyc(1, 1, 0, 8'h00, 1, 3, "full_drain");
    apply(1, 1, 0, 8'h00, 0, 3);
    check("full_drained", 32'(dut_out()), 32'({1'b1, 1'b0, 8'h00, 1'b0, 6'd32}));
    commit();
    $display("seq full/reopen done");

    // Packet request threshold and live pkt_len changes.
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 8'(i + 8'h40), 0, 1, "req_fill");
    apply(1, 1, 0, 8'h00, 0, 1); check("req_7of8", 32'(slv_req), 32'(0)); commit();
    cyc(1, 1, 1, 8'h47, 0, 1, "req_push8");
    apply(1, 1, 0, 8'h00, 0, 1); check("req_8of8", 32'(slv_req), 32'(1)); commit();
    apply(1, 1, 0, 8'h00, 0, 0); check("req_len4", 32'(slv_req), 32'(1)); commit();
    apply(1, 1, 0, 8'h00, 0, 2); check("req_len16", 32'(slv_req), 32'(0)); commit();
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 8'h00, 1, 2, "req_drain");
    $display("seq pkt_len done");

    // Steady push+pop at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 8'($urandom), 0, 0, "steady_fill");
    for (int i = 0; i < 100; i++) cyc(1, 1, 1, 8'($urandom), 1, 0, "steady");
    apply(1, 1, 0, 8'h00, 0, 0); check("steady_margin", 32'(margin), 32'(28)); commit();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 8'h00, 1, 0, "steady_drain");
    $display("seq steady done");

    // Disable with 10 words buffered; drain still works.
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 8'(8'h80 + i), 0, 0, "en_fill");
    apply(1, 0, 1, 8'hEE, 0, 0);
    check("en_off_ready", 32'(ch_ready), 32'(0));
    check("en_off_req", 32'(slv_req), 32'(0));
    commit();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'h00, 1, 0, "en_drain");
    $display("seq slv_en drop done");

    // Asynchronous reset with 12 words buffered.
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 8'($urandom), 0, 0, "rst_fill");
    @(negedge clk);
    ch_valid = 1'b0; slv_pop = 1'b0;
    #2 rstn = 1'b0;
    #1 check("async_rst", 32'(dut_out()), 32'({1'b0, 1'b0, 8'h00, 1'b0, 6'd32}));
    q.delete();
    cyc(0, 1, 1, 8'h11, 0, 0, "in_rst");
    cyc(1, 1, 1, 8'h5C, 0, 0, "post_rst_push");
    apply(1, 1, 0, 8'h00, 0, 0); check("post_rst_head", 32'(slv_data), 32'(8'h5C)); commit();
    cyc(1, 1, 0, 8'h00, 1, 0, "post_rst_pop");
    $display("seq async reset done");

    // Randomized traffic with pop bias alternating to exercise full and empty.
    for (int i = 0; i < 2000; i++) begin
      int pop_pct;
      pop_pct = ((i / 200) % 2 == 0) ? 30 : 75;
      cyc(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 65), 8'($urandom),
          ($urandom_range(0, 99) < pop_pct), 3'($urandom), "random");
    end
    $display("seq random done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
